alu_mdu: RTL and testbench

//   Parametrised execute-stage ALU with an integrated RV32M multiply/divide unit.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/mdu_iter.sv | 62 ++++++
 rtl/alu_mdu.sv | 126 ++++++++++++
 tb/tb_alu_mdu.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and decode helpers for the execute-stage ALU/MDU.
package alu_pkg;

    localparam logic [4:0] MODE_ADD    = 5'd0;
    localparam logic [4:0] MODE_SUB    = 5'd1;
    localparam logic [4:0] MODE_SLL    = 5'd2;
    localparam logic [4:0] MODE_SLT    = 5'd3;
    localparam logic [4:0] MODE_SLTU   = 5'd4;
    localparam logic [4:0] MODE_XOR    = 5'd5;
    localparam logic [4:0] MODE_SRL    = 5'd6;
    localparam logic [4:0] MODE_SRA    = 5'd7;
    localparam logic [4:0] MODE_OR     = 5'd8;
    localparam logic [4:0] MODE_AND    = 5'd9;
    localparam logic [4:0] MODE_MUL    = 5'd16;
    localparam logic [4:0] MODE_MULH   = 5'd17;
    localparam logic [4:0] MODE_MULHSU = 5'd18;
    localparam logic [4:0] MODE_MULHU  = 5'd19;
    localparam logic [4:0] MODE_DIV    = 5'd20;
    localparam logic [4:0] MODE_DIVU   = 5'd21;
    localparam logic [4:0] MODE_REM    = 5'd22;
    localparam logic [4:0] MODE_REMU   = 5'd23;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINAL} state_t;

    // Codes 16..23 are the multi-cycle M extension ops.
    function automatic logic is_mdiv(input logic [4:0] mode);
        return mode[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative datapath: shift-add multiply (LSB first) or restoring divide, one bit per cycle.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              start,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic              done,
    output logic [2*XLEN-1:0] acc
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]   opnd;
    logic              div_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc_q, acc_nxt;
    logic [2*XLEN:0]   sh;
    logic [XLEN:0]     trial, sum;

    // Divide: acc = {remainder, quotient}; multiply: acc = {partial hi, multiplier shifting out}.
    always_comb begin
        acc_nxt = acc_q;
        sh      = '0;
        trial   = '0;
        sum     = '0;
        if (div_q) begin
            sh    = {acc_q, 1'b0};
            trial = sh[2*XLEN:XLEN] - {1'b0, opnd};
            if (sh[2*XLEN:XLEN] >= {1'b0, opnd})
                acc_nxt = {trial[XLEN-1:0], sh[XLEN-1:1], 1'b1};
            else
                acc_nxt = sh[2*XLEN-1:0];
        end else begin
            sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd} : '0);
            acc_nxt = {sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            opnd  <= '0;
            div_q <= 1'b0;
            cnt   <= '0;
            acc_q <= '0;
        end else if (start) begin
            opnd  <= is_div ? b_mag : a_mag;
            acc_q <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            div_q <= is_div;
            cnt   <= CNT_W'(XLEN);
        end else if (cnt != '0) begin
            acc_q <= acc_nxt;
            cnt   <= cnt - 1'b1;
        end
    end

    assign done = (cnt == CNT_W'(1));
    assign acc  = acc_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: single-cycle base ops plus an iterative RV32M multiply/divide unit.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [4:0]      i_mode,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_valid,
    output logic            o_stall
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic              accept, m_op, is_div, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, ovf, early, start, done, neg_flag, neg_q;
    logic [4:0]        mode_q;
    logic [XLEN-1:0]   a_mag, b_mag, base_res, early_res, fin_res, dq;
    logic [2*XLEN-1:0] acc, prod;
    logic [SH_W-1:0]   shamt;

    assign accept = i_valid && (state == S_IDLE);
    assign m_op   = is_mdiv(i_mode);
    assign is_div = i_mode[2];
    assign shamt  = i_b[SH_W-1:0];

    always_comb begin
        base_res = '0;
        case (i_mode)
            MODE_ADD:  base_res = i_a + i_b;
            MODE_SUB:  base_res = i_a - i_b;
            MODE_SLL:  base_res = i_a << shamt;
            MODE_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            MODE_SLTU: base_res = {{(XLEN-1){1'b0}}, i_a < i_b};
            MODE_XOR:  base_res = i_a ^ i_b;
            MODE_SRL:  base_res = i_a >> shamt;
            MODE_SRA:  base_res = $unsigned($signed(i_a) >>> shamt);
            MODE_OR:   base_res = i_a | i_b;
            MODE_AND:  base_res = i_a & i_b;
            default:   base_res = '0;
        endcase
    end

    // MULHSU treats B as unsigned; MULHU/DIVU/REMU treat both as unsigned.
    assign a_signed = (i_mode == MODE_MUL) || (i_mode == MODE_MULH) || (i_mode == MODE_MULHSU) ||
                      (i_mode == MODE_DIV) || (i_mode == MODE_REM);
    assign b_signed = (i_mode == MODE_MUL) || (i_mode == MODE_MULH) ||
                      (i_mode == MODE_DIV) || (i_mode == MODE_REM);
    assign a_neg    = a_signed && i_a[XLEN-1];
    assign b_neg    = b_signed && i_b[XLEN-1];
    assign a_mag    = a_neg ? -i_a : i_a;
    assign b_mag    = b_neg ? -i_b : i_b;
    // Remainder follows the dividend's sign; everything else follows the sign product.
    assign neg_flag = (is_div && i_mode[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero  = m_op && is_div && (i_b == '0);
    assign ovf       = ((i_mode == MODE_DIV) || (i_mode == MODE_REM)) &&
                       (i_a == MIN_INT) && (i_b == '1);
    assign early     = div_zero || ovf;
    assign early_res = div_zero ? (i_mode[1] ? i_a : '1) : (i_mode[1] ? '0 : MIN_INT);
    assign start     = accept && m_op && !early;

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .start   (start),
        .is_div  (is_div),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .done    (done),
        .acc     (acc)
    );

    always_comb begin
        prod    = neg_q ? -acc : acc;
        dq      = mode_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        fin_res = '0;
        if (mode_q[2])
            fin_res = neg_q ? -dq : dq;
        else
            fin_res = (mode_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (done)  state_nxt = S_FINAL;
            S_FINAL: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            o_result <= '0;
            o_valid  <= 1'b0;
            neg_q    <= 1'b0;
            mode_q   <= '0;
        end else begin
            state   <= state_nxt;
            o_valid <= 1'b0;
            if (start) begin
                neg_q  <= neg_flag;
                mode_q <= i_mode;
            end
            if (accept && (!m_op || early)) begin
                o_result <= m_op ? early_res : base_res;
                o_valid  <= 1'b1;
            end else if (state == S_FINAL) begin
                o_result <= fin_res;
                o_valid  <= 1'b1;
            end
        end
    end

    assign o_stall = (state != S_IDLE);

endmodule

// File: tb/tb_alu_mdu.sv
// Directed vector bench for alu_mdu (XLEN=32): result values, latency, stall and reset behaviour.
module tb_alu_mdu;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [4:0]  i_mode;
    logic [31:0] i_a, i_b;
    logic [31:0] o_result;
    logic        o_valid, o_stall;

    int checks = 0;
    int fails  = 0;

    alu_mdu #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_mode   (i_mode),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_result (o_result),
        .o_valid  (o_valid),
        .o_stall  (o_stall)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one op from idle and follow it until o_valid (bounded).
    task automatic run_op(input string nm, input logic [4:0] m, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int  k;
        bit  st_ok;
        i_valid = 1'b1; i_mode = m; i_a = a; i_b = b;
        tick();
        i_valid = 1'b0;
        k = 1;
        st_ok = 1'b1;
        while (!o_valid && k < 100) begin
            if (!o_stall) st_ok = 1'b0;
            tick();
            k++;
        end
        chk({nm, " latency"}, 32'(k), 32'(lat));
        chk({nm, " result"}, o_result, exp);
        chk({nm, " stall_at_valid"}, {31'b0, o_stall}, 32'd0);
        if (lat > 1) chk({nm, " stall_during"}, {31'b0, st_ok}, 32'd1);
    endtask

    initial begin
        // mode, a, b, expected, latency
        vt.push_back('{5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
        vt.push_back('{5'd2,  32'h00000001, 32'h00000021, 32'h00000002, 1});
        vt.push_back('{5'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
        vt.push_back('{5'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
        vt.push_back('{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1});
        vt.push_back('{5'd6,  32'h80000000, 32'h00000004, 32'h08000000, 1});
        vt.push_back('{5'd7,  32'h80000000, 32'h00000004, 32'hF8000000, 1});
        vt.push_back('{5'd8,  32'hF0000000, 32'h0000000F, 32'hF000000F, 1});
        vt.push_back('{5'd9,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1});
        vt.push_back('{5'd10, 32'h12345678, 32'h11111111, 32'h00000000, 1});
        vt.push_back('{5'd31, 32'h12345678, 32'h11111111, 32'h00000000, 1});
        vt.push_back('{5'd17, 32'h80000000, 32'h80000000, 32'h40000000, 34});
        vt.push_back('{5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vt.push_back('{5'd16, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34});
        vt.push_back('{5'd18, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34});
        vt.push_back('{5'd20, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34});
        vt.push_back('{5'd22, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34});
        vt.push_back('{5'd21, 32'd64,       32'd7,        32'd9,        34});
        vt.push_back('{5'd23, 32'd64,       32'd7,        32'd1,        34});
        vt.push_back('{5'd20, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 34});
        vt.push_back('{5'd22, 32'd20,       32'hFFFFFFFD, 32'h00000002, 34});
        vt.push_back('{5'd21, 32'hFFFFFFFF, 32'd10,       32'h19999999, 34});
        vt.push_back('{5'd21, 32'd1234,     32'd0,        32'hFFFFFFFF, 1});
        vt.push_back('{5'd22, 32'd1234,     32'd0,        32'd1234,     1});
        vt.push_back('{5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vt.push_back('{5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});

        i_rst_n = 1'b0; i_valid = 1'b0; i_mode = '0; i_a = '0; i_b = '0;
        #12;
        chk("reset result", o_result, 32'd0);
        chk("reset valid", {31'b0, o_valid}, 32'd0);
        chk("reset stall", {31'b0, o_stall}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();

        foreach (vt[i])
            run_op($sformatf("vec%0d", i), vt[i].mode, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

        // Back-to-back base ops: ADD then SUB accepted on the following edge.
        tick();
        i_valid = 1'b1; i_mode = 5'd0; i_a = 32'hFFFFFFFF; i_b = 32'd1;
        tick();
        i_mode = 5'd1; i_a = 32'd5; i_b = 32'd7;
        chk("b2b add valid", {31'b0, o_valid}, 32'd1);
        chk("b2b add result", o_result, 32'd0);
        tick();
        i_valid = 1'b0;
        chk("b2b sub valid", {31'b0, o_valid}, 32'd1);
        chk("b2b sub result", o_result, 32'hFFFFFFFE);
        tick();
        chk("b2b pulse end", {31'b0, o_valid}, 32'd0);

        // ADD presented mid-divide must be ignored.
        begin
            int k;
            int first_v;
            first_v = 0;
            i_valid = 1'b1; i_mode = 5'd20; i_a = 32'd100; i_b = 32'd7;
            tick();
            i_valid = 1'b0;
            for (k = 1; k <= 36; k++) begin
                if (k == 4) begin i_valid = 1'b1; i_mode = 5'd0; i_a = 32'd1; i_b = 32'd1; end
                if (k == 5) i_valid = 1'b0;
                if (o_valid && first_v == 0) begin
                    first_v = k;
                    chk("ignore div result", o_result, 32'd14);
                end
                tick();
            end
            chk("ignore first valid cycle", 32'(first_v), 32'd34);
            chk("ignore no extra valid", {31'b0, o_valid}, 32'd0);
        end

        // Reset in the middle of a multiply discards it.
        begin
            int seen;
            seen = 0;
            i_valid = 1'b1; i_mode = 5'd16; i_a = 32'd3; i_b = 32'd5;
            tick();
            i_valid = 1'b0;
            repeat (9) tick();
            chk("pre-reset stall", {31'b0, o_stall}, 32'd1);
            i_rst_n = 1'b0;
            #1;
            chk("mid reset result", o_result, 32'd0);
            chk("mid reset stall", {31'b0, o_stall}, 32'd0);
            chk("mid reset valid", {31'b0, o_valid}, 32'd0);
            tick();
            tick();
            i_rst_n = 1'b1;
            for (int k = 0; k < 40; k++) begin
                if (o_valid || o_stall) seen++;
                tick();
            end
            chk("post reset quiet", 32'(seen), 32'd0);
            run_op("post reset add", 5'd0, 32'd2, 32'd3, 32'd5, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
